trace_capture_ctrl: RTL and testbench
=====================================

Name: trace_capture_ctrl

Overview:
Controller sequencing capture of retired-instruction trace records into an on-chip circular buffer and draining them to a downstream consumer (UART bridge or testbench sink). It sits beside the CPU write-back stage and takes the same per-retire trace fields the console tracer prints. Capture is armed by software or the bench, fires on a masked instruction match, keeps a pre-trigger history window, then drains oldest-first over a valid/ready stream.

Parameters:
DEPTH, 16, buffer entries; power of two, >= 4
PRE_TRIG, 4, entries of history retained before trigger; 1 <= PRE_TRIG < DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
arm  in  1  pulse: start capture session (honoured only in IDLE)
abort  in  1  pulse: discard session, return to IDLE
trig_instr  in  32  trigger instruction pattern
trig_mask  in  32  trigger compare mask (1 = compare bit)
ret_valid  in  1  an instruction retires this cycle
ret_instr  in  32  retired instruction word
ret_rd_value  in  32  value written to rd (signed)
ret_imm  in  12  decoded immediate (signed)
ret_rd, ret_rs1, ret_rs2  in  5 each  register indices
out_valid  out  1  out_record valid
out_ready  in  1  consumer accepts record
out_record  out  91  {instr, rd_value, rd, rs1, rs2, imm}, MSB first
state  out  2  IDLE=0, PRE=1, POST=2, DRAIN=3
done  out  1  one-cycle pulse when the last record is accepted

Behaviour:
- Reset: state IDLE, wr/rd pointers 0, occupancy 0, out_valid 0, done 0, out_record 0. Buffer contents need no reset.
- Trigger hit = ret_valid && ((ret_instr ^ trig_instr) & trig_mask) == 0. Evaluated in PRE only.
- IDLE: retires ignored. arm -> PRE, with pointers and occupancy cleared. The retire in the arm cycle is not captured.
- PRE: each non-hit retire is written at wr_ptr. When occupancy == PRE_TRIG, the write also advances rd_ptr (oldest dropped), so occupancy saturates at PRE_TRIG. On a hit, write the record and go to POST; the hit record is always stored.
- POST: each retire is written. When the write brings occupancy to DEPTH, go to DRAIN on the next edge. If the hit already fills DEPTH, PRE goes directly to DRAIN.
- DRAIN: retires ignored. out_valid = (occupancy != 0). out_record = entry[rd_ptr], combinational from the array. Transfer on out_valid && out_ready: rd_ptr+1, occupancy-1. Accepting the last entry pulses done one cycle later and returns to IDLE. out_valid first rises in the cycle after entering DRAIN.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- out_record must stay stable while out_valid && !out_ready.
- abort in any state: IDLE next cycle, pointers and occupancy cleared, out_valid 0 next cycle, no done pulse. abort has priority over arm and over a same-cycle transfer.
- arm outside IDLE is ignored.
- rst_n low mid-session: identical to reset; any in-flight transfer is lost.

Decomposition:
- Shared package trace_pkg holds: the state encodings; the record field offsets and widths (REC_W=91, INSTR_MSB, etc.); and a function that packs the record from the fields.
- One natural sub-module, trace_ring_buf: DEPTH x REC_W register array with write port (we, waddr, wdata) and asynchronous read port. All pointer, occupancy and FSM logic lives in trace_capture_ctrl.

Test Plan (DEPTH=8, PRE_TRIG=3, trig_mask=32'hFFFFFFFF, trig_instr=32'h00500093):
- Basic window: arm; retire instr A1..A5 (non-hit), hit H, then B1..B5 every cycle with out_ready=1 -> drained order A3,A4,A5,H,B1..B4 (8 records); B5 not captured; done pulses once; state returns to 0.
- Backpressure: same stimulus, out_ready toggles 1010...; out_record held while stalled -> 8 transfers in order, no duplicates or drops.
- Immediate hit: arm, then first retire = H, then 7 more retires -> drain H first, 8 records total. Occupancy before the hit never exceeded 0.
- Masked trigger: trig_mask=32'h0000007F, trig_instr=32'h00000033; retire 32'h40B50533 -> treated as hit, state 1->2.
- Abort mid-DRAIN after 3 transfers -> out_valid 0 next cycle, state 0, no done. A following arm starts with occupancy 0.
- Arm during POST ignored; rst_n low for 1 cycle in POST -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the retire-trace capture controller: FSM encodings,
// trace record layout and the record packing / trigger compare helpers.
package trace_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int INSTR_W = 32;
    localparam int VALUE_W = 32;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 12;
    localparam int REC_W   = INSTR_W + VALUE_W + 3 * REG_W + IMM_W;

    // Record layout, MSB first: {instr, rd_value, rd, rs1, rs2, imm}
    localparam int IMM_LSB   = 0;
    localparam int IMM_MSB   = IMM_LSB + IMM_W - 1;
    localparam int RS2_LSB   = IMM_MSB + 1;
    localparam int RS2_MSB   = RS2_LSB + REG_W - 1;
    localparam int RS1_LSB   = RS2_MSB + 1;
    localparam int RS1_MSB   = RS1_LSB + REG_W - 1;
    localparam int RD_LSB    = RS1_MSB + 1;
    localparam int RD_MSB    = RD_LSB + REG_W - 1;
    localparam int VALUE_LSB = RD_MSB + 1;
    localparam int VALUE_MSB = VALUE_LSB + VALUE_W - 1;
    localparam int INSTR_LSB = VALUE_MSB + 1;
    localparam int INSTR_MSB = INSTR_LSB + INSTR_W - 1;

    function automatic logic [REC_W-1:0] pack_record(
        input logic        [INSTR_W-1:0] instr,
        input logic signed [VALUE_W-1:0] rd_value,
        input logic        [REG_W-1:0]   rd,
        input logic        [REG_W-1:0]   rs1,
        input logic        [REG_W-1:0]   rs2,
        input logic signed [IMM_W-1:0]   imm
    );
        logic [REC_W-1:0] rec;
        rec                      = '0;
        rec[INSTR_MSB:INSTR_LSB] = instr;
        rec[VALUE_MSB:VALUE_LSB] = rd_value;
        rec[RD_MSB:RD_LSB]       = rd;
        rec[RS1_MSB:RS1_LSB]     = rs1;
        rec[RS2_MSB:RS2_LSB]     = rs2;
        rec[IMM_MSB:IMM_LSB]     = imm;
        return rec;
    endfunction

    function automatic logic trig_match(
        input logic [INSTR_W-1:0] instr,
        input logic [INSTR_W-1:0] pattern,
        input logic [INSTR_W-1:0] mask
    );
        return ((instr ^ pattern) & mask) == '0;
    endfunction

endpackage

// File: rtl/trace_ring_buf.sv
// Circular trace storage: one synchronous write port and an asynchronous read
// port. Contents are deliberately not reset; occupancy tracking lives outside.
module trace_ring_buf
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [REC_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [REC_W-1:0] rdata
);

    logic [REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_ctrl.sv
// Retire-trace capture controller: arms, keeps a pre-trigger history window,
// captures until the ring is full, then drains oldest-first over valid/ready.
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [INSTR_W-1:0]       trig_instr,
    input  logic [INSTR_W-1:0]       trig_mask,
    input  logic                     ret_valid,
    input  logic [INSTR_W-1:0]       ret_instr,
    input  logic signed [VALUE_W-1:0] ret_rd_value,
    input  logic signed [IMM_W-1:0]  ret_imm,
    input  logic [REG_W-1:0]         ret_rd,
    input  logic [REG_W-1:0]         ret_rs1,
    input  logic [REG_W-1:0]         ret_rs2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [REC_W-1:0]         out_record,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PRE_OCC  = (AW + 1)'(PRE_TRIG);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_OCC  = (AW + 1)'(1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [AW:0]      occ_inc;
    logic             hit;
    logic             capture;
    logic             xfer;
    logic [REC_W-1:0] wdata;
    logic [REC_W-1:0] rdata;

    always_comb begin
        occ_inc   = occ + ONE_OCC;
        hit       = ret_valid && trig_match(ret_instr, trig_instr, trig_mask);
        capture   = ret_valid && ((state == ST_PRE) || (state == ST_POST));
        out_valid = (state == ST_DRAIN) && (occ != '0);
        xfer      = out_valid && out_ready;
        // Unread array contents must never leak out while not draining.
        out_record = out_valid ? rdata : '0;
        wdata      = pack_record(ret_instr, ret_rd_value, ret_rd, ret_rs1, ret_rs2, ret_imm);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            state  <= ST_PRE;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            occ    <= '0;
                        end
                    end
                    ST_PRE: begin
                        if (capture) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (hit) begin
                                occ   <= occ_inc;
                                state <= (occ_inc == FULL_OCC) ? ST_DRAIN : ST_POST;
                            end else if (occ == PRE_OCC) begin
                                // History window full: slide it, dropping the oldest entry.
                                rd_ptr <= rd_ptr + 1'b1;
                            end else begin
                                occ <= occ_inc;
                            end
                        end
                    end
                    ST_POST: begin
                        if (capture) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            occ    <= occ_inc;
                            if (occ_inc == FULL_OCC) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (xfer) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            occ    <= occ - ONE_OCC;
                            if (occ == ONE_OCC) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    trace_ring_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Scenario bench for trace_capture_ctrl (DEPTH=8, PRE_TRIG=3) with a capture
// window model feeding an expected-record queue checked during drain.
module tb_trace_capture_ctrl;

    localparam int DEPTH    = 8;
    localparam int PRE_TRIG = 3;
    localparam logic [31:0] H = 32'h00500093;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        abort;
    logic [31:0] trig_instr;
    logic [31:0] trig_mask;
    logic        ret_valid;
    logic [31:0] ret_instr;
    logic signed [31:0] ret_rd_value;
    logic signed [11:0] ret_imm;
    logic [4:0]  ret_rd;
    logic [4:0]  ret_rs1;
    logic [4:0]  ret_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [90:0] out_record;
    logic [1:0]  state;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic [90:0] exp_q[$];
    int m_phase = 0;  // 0 idle, 1 pre, 2 post, 3 full

    trace_capture_ctrl #(.DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .trig_instr(trig_instr), .trig_mask(trig_mask),
        .ret_valid(ret_valid), .ret_instr(ret_instr), .ret_rd_value(ret_rd_value),
        .ret_imm(ret_imm), .ret_rd(ret_rd), .ret_rs1(ret_rs1), .ret_rs2(ret_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [90:0] got, input logic [90:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
        if (m_phase == 0) begin
            exp_q.delete();
            m_phase = 1;
        end
    endtask

    task automatic retire(input logic [31:0] instr, input int seed);
        logic [31:0] s;
        logic [90:0] rec;
        s = 32'(seed) * 32'h9E3779B1;
        ret_instr    = instr;
        ret_rd_value = s ^ 32'h8000_0000;
        ret_imm      = s[11:0] ^ 12'h800;
        ret_rd       = s[16:12];
        ret_rs1      = s[21:17];
        ret_rs2      = s[26:22];
        ret_valid    = 1'b1;
        rec = {ret_instr, ret_rd_value, ret_rd, ret_rs1, ret_rs2, ret_imm};
        if (m_phase == 1) begin
            exp_q.push_back(rec);
            if (((instr ^ trig_instr) & trig_mask) == 32'd0) begin
                m_phase = (exp_q.size() == DEPTH) ? 3 : 2;
            end else if (exp_q.size() > PRE_TRIG) begin
                void'(exp_q.pop_front());
            end
        end else if (m_phase == 2) begin
            exp_q.push_back(rec);
            if (exp_q.size() == DEPTH) m_phase = 3;
        end
        step();
        ret_valid = 1'b0;
    endtask

    // Accepts records until total (or stop_after) transfers, comparing each
    // presented record against the queue head and checking stall stability.
    task automatic drain_check(input bit toggle, input int stop_after, input int total, input int budget);
        int accepted = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit finished = 1'b0;
        bit rdy;
        logic [90:0] held = '0;
        while (cyc < budget && !finished) begin
            chk("done_early", {90'd0, done}, 91'd0);
            if (out_valid === 1'b1) begin
                if (stalled) chk("record_hold", out_record, held);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_record: got %h expected none", out_record);
                end else begin
                    chk("record_order", out_record, exp_q[0]);
                end
            end
            if (stop_after >= 0 && accepted == stop_after) break;
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                accepted++;
                stalled = 1'b0;
            end else if (out_valid === 1'b1) begin
                stalled = 1'b1;
                held = out_record;
            end
            step();
            cyc++;
            if (accepted == total) finished = 1'b1;
        end
        out_ready = 1'b0;
        if (stop_after >= 0) begin
            chk("partial_count", 91'(accepted), 91'(stop_after));
        end else begin
            chk("drain_count", 91'(accepted), 91'(total));
            chk("done_pulse", {90'd0, done}, 91'd1);
            chk("state_idle_after", {89'd0, state}, 91'd0);
            chk("valid_after", {90'd0, out_valid}, 91'd0);
            chk("queue_empty", 91'(exp_q.size()), 91'd0);
            step();
            chk("done_single", {90'd0, done}, 91'd0);
            m_phase = 0;
        end
    endtask

    task automatic test_reset();
        chk("rst_state", {89'd0, state}, 91'd0);
        chk("rst_valid", {90'd0, out_valid}, 91'd0);
        chk("rst_done", {90'd0, done}, 91'd0);
        chk("rst_record", out_record, 91'd0);
    endtask

    task automatic test_window(input bit toggle);
        fork
            begin
                arm_pulse();
                chk("armed_state", {89'd0, state}, 91'd1);
                for (int i = 1; i <= 5; i++) retire(32'h00000013 | (32'(i) << 20), i);
                retire(H, 100);
                chk("post_state", {89'd0, state}, 91'd2);
                for (int i = 1; i <= 5; i++) retire(32'h00000133 | (32'(i) << 7), 200 + i);
            end
            drain_check(toggle, -1, DEPTH, 80);
        join
    endtask

    task automatic fill_immediate(input int base);
        arm_pulse();
        retire(H, base);
        chk("imm_hit_state", {89'd0, state}, 91'd2);
        for (int i = 1; i <= 7; i++) retire(32'h00000213 | (32'(i) << 20), base + i);
        chk("drain_state", {89'd0, state}, 91'd3);
    endtask

    task automatic test_immediate_hit();
        fill_immediate(300);
        chk("imm_first_is_hit", {59'd0, out_record[90:59]}, {59'd0, H});
        drain_check(1'b0, -1, DEPTH, 40);
    endtask

    task automatic test_masked_trigger();
        trig_mask  = 32'h0000007F;
        trig_instr = 32'h00000033;
        arm_pulse();
        retire(32'h00A00013, 400);
        chk("mask_nohit_state", {89'd0, state}, 91'd1);
        retire(32'h40B50533, 401);
        chk("mask_hit_state", {89'd0, state}, 91'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        m_phase = 0;
        exp_q.delete();
        chk("mask_abort_state", {89'd0, state}, 91'd0);
        trig_mask  = 32'hFFFFFFFF;
        trig_instr = H;
    endtask

    task automatic test_abort_drain();
        fill_immediate(500);
        drain_check(1'b0, 3, DEPTH, 40);
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        m_phase = 0;
        exp_q.delete();
        chk("abort_valid", {90'd0, out_valid}, 91'd0);
        chk("abort_state", {89'd0, state}, 91'd0);
        chk("abort_no_done", {90'd0, done}, 91'd0);
        step();
        chk("abort_no_done_late", {90'd0, done}, 91'd0);
        fill_immediate(600);
        drain_check(1'b0, -1, DEPTH, 40);
    endtask

    task automatic test_post_arm_and_reset();
        arm_pulse();
        retire(32'h00100013, 700);
        retire(H, 701);
        chk("post_entry", {89'd0, state}, 91'd2);
        arm_pulse();
        chk("arm_ignored", {89'd0, state}, 91'd2);
        retire(32'h00200013, 702);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_phase = 0;
        exp_q.delete();
        test_reset();
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; out_ready = 1'b0;
        trig_instr = H; trig_mask = 32'hFFFFFFFF;
        ret_valid = 1'b0; ret_instr = '0; ret_rd_value = '0; ret_imm = '0;
        ret_rd = '0; ret_rs1 = '0; ret_rs2 = '0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_window(1'b0);
        test_window(1'b1);
        test_immediate_hit();
        test_masked_trigger();
        test_abort_drain();
        test_post_arm_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
